// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter command sequencer.
package counter_seq_pkg;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_LEN_W      = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD     = 2'd0,
    OP_UP       = 2'd1,
    OP_DOWN     = 2'd2,
    OP_WAIT_OVF = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT_OVF
  } state_e;

  typedef struct packed {
    op_e                  op;
    logic [DEF_CNT_W-1:0] value;
    logic [DEF_LEN_W-1:0] len;
  } cmd_t;

endpackage

// File: rtl/counter_cmd_seq_if.sv
// Command push port (valid/ready) of the counter command sequencer.
interface counter_cmd_seq_if
  import counter_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LEN_W = DEF_LEN_W
);
  logic             cmd_valid_in;
  logic             cmd_ready_out;
  logic [1:0]       cmd_op_in;
  logic [CNT_W-1:0] cmd_value_in;
  logic [LEN_W-1:0] cmd_len_in;

  modport master (
    output cmd_valid_in, cmd_op_in, cmd_value_in, cmd_len_in,
    input  cmd_ready_out
  );

  modport slave (
    input  cmd_valid_in, cmd_op_in, cmd_value_in, cmd_len_in,
    output cmd_ready_out
  );
endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO of command words; head is visible without a read strobe.
module cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/counter_cmd_seq.sv
// Pops queued counter commands and plays each as a cycle-exact en/set/up/load sequence.
module counter_cmd_seq
  import counter_seq_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  counter_cmd_seq_if.slave cmd,
  input  logic             ovf_in,
  output logic             en_ctrl_out,
  output logic             set_ctrl_out,
  output logic             up_ctrl_out,
  output logic [CNT_W-1:0] counter_val_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             timeout_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = LEN_W + 1;

  typedef struct packed {
    op_e              op;
    logic [CNT_W-1:0] value;
    logic [LEN_W-1:0] len;
  } seq_cmd_t;

  seq_cmd_t      push_data;
  seq_cmd_t      head;
  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  state_e           state_reg, state_next;
  logic [LW-1:0]    len_reg, len_next;
  logic             en_reg, en_next;
  logic             set_reg, set_next;
  logic             up_reg, up_next;
  logic [CNT_W-1:0] val_reg, val_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             timeout_reg, timeout_next;

  assign push              = cmd.cmd_valid_in && !full;
  assign cmd.cmd_ready_out = !full;
  assign push_data         = '{op: op_e'(cmd.cmd_op_in), value: cmd.cmd_value_in, len: cmd.cmd_len_in};

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (seq_cmd_t)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Outputs are registered alongside the state, so they change on the pop edge itself.
  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    en_next      = 1'b0;
    set_next     = 1'b0;
    up_next      = up_reg;
    val_next     = val_reg;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    pop          = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          len_next = (head.len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, head.len};
          unique case (head.op)
            OP_LOAD: begin
              state_next = S_LOAD;
              set_next   = 1'b1;
              val_next   = head.value;
            end
            OP_UP, OP_DOWN: begin
              state_next = S_RUN;
              en_next    = 1'b1;
              up_next    = (head.op == OP_UP);
            end
            OP_WAIT_OVF: begin
              state_next = S_WAIT_OVF;
              en_next    = 1'b1;
              up_next    = head.value[0];
            end
          endcase
        end
      end
      S_LOAD: begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
      S_RUN: begin
        if (len_reg == LW'(1)) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          len_next = len_reg - LW'(1);
          en_next  = 1'b1;
        end
      end
      S_WAIT_OVF: begin
        // Overflow is checked first so it beats a timeout on the same cycle.
        if (ovf_in) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else if (len_reg == LW'(1)) begin
          state_next   = S_IDLE;
          done_next    = 1'b1;
          timeout_next = 1'b1;
        end else begin
          len_next = len_reg - LW'(1);
          en_next  = 1'b1;
        end
      end
    endcase
    count_next = count + CW'(push) - CW'(pop);
    busy_next  = (state_next != S_IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg   <= S_IDLE;
      len_reg     <= '0;
      en_reg      <= 1'b0;
      set_reg     <= 1'b0;
      up_reg      <= 1'b0;
      val_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      en_reg      <= en_next;
      set_reg     <= set_next;
      up_reg      <= up_next;
      val_reg     <= val_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  assign en_ctrl_out     = en_reg;
  assign set_ctrl_out    = set_reg;
  assign up_ctrl_out     = up_reg;
  assign counter_val_out = val_reg;
  assign busy_out        = busy_reg;
  assign done_out        = done_reg;
  assign timeout_out     = timeout_reg;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq: cycle traces compared against hand-derived vectors.
module tb_counter_cmd_seq;
  import counter_seq_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       ovf_in;
  logic       en_ctrl_out, set_ctrl_out, up_ctrl_out;
  logic [7:0] counter_val_out;
  logic       busy_out, done_out, timeout_out;

  always #5 clk_in = ~clk_in;

  counter_cmd_seq_if #(.CNT_W(8), .LEN_W(8)) cmd_if ();

  counter_cmd_seq #(
    .CNT_W      (8),
    .LEN_W      (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .cmd             (cmd_if),
    .ovf_in          (ovf_in),
    .en_ctrl_out     (en_ctrl_out),
    .set_ctrl_out    (set_ctrl_out),
    .up_ctrl_out     (up_ctrl_out),
    .counter_val_out (counter_val_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .timeout_out     (timeout_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Passive monitor: counts done pulses and logs every load strobe value.
  int         done_seen = 0;
  logic [7:0] set_log [$];
  always @(negedge clk_in) begin
    if (done_out) done_seen++;
    if (set_ctrl_out) set_log.push_back(counter_val_out);
  end

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] value, input logic [7:0] len);
    int guard;
    guard = 0;
    @(negedge clk_in);
    cmd_if.cmd_valid_in = 1'b1;
    cmd_if.cmd_op_in    = op;
    cmd_if.cmd_value_in = value;
    cmd_if.cmd_len_in   = len;
    while (!cmd_if.cmd_ready_out && guard < 2000) begin
      @(negedge clk_in);
      guard++;
    end
    if (guard >= 2000) check("push_ready_wait", 32'(guard), 0);
    @(posedge clk_in);
    #1;
    cmd_if.cmd_valid_in = 1'b0;
    $display("push op=%0d value=0x%02h len=%0d", op, value, len);
  endtask

  // Bit k of each trace is the output sampled on the k-th falling edge.
  task automatic capture(input int n, input int ovf_at,
                         output logic [31:0] en_t, output logic [31:0] up_t,
                         output logic [31:0] done_t, output logic [31:0] to_t);
    en_t = '0; up_t = '0; done_t = '0; to_t = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      en_t[k]   = en_ctrl_out;
      up_t[k]   = up_ctrl_out;
      done_t[k] = done_out;
      to_t[k]   = timeout_out;
      ovf_in    = (k == ovf_at);
    end
    ovf_in = 1'b0;
  endtask

  logic [31:0] en_t, up_t, done_t, to_t;
  int          n_en, base_done, base_set;
  logic        got_done, got_to;
  logic [7:0]  exp_loads [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    ovf_in = 1'b0;
    cmd_if.cmd_valid_in = 1'b0;
    cmd_if.cmd_op_in    = '0;
    cmd_if.cmd_value_in = '0;
    cmd_if.cmd_len_in   = '0;
    repeat (3) @(negedge clk_in);
    check("rst_en",      en_ctrl_out, 0);
    check("rst_set",     set_ctrl_out, 0);
    check("rst_up",      up_ctrl_out, 0);
    check("rst_val",     counter_val_out, 0);
    check("rst_done",    done_out | timeout_out, 0);
    check("rst_busy",    busy_out, 0);
    check("rst_ready",   cmd_if.cmd_ready_out, 1);
    rst_in = 1'b0;

    // LOAD 0xA5: one strobe cycle, done on the following cycle.
    push_cmd(OP_LOAD, 8'hA5, 8'd0);
    @(negedge clk_in);
    check("load_pre_set",  set_ctrl_out, 0);
    check("load_pre_busy", busy_out, 1);
    @(negedge clk_in);
    check("load_set",  set_ctrl_out, 1);
    check("load_val",  counter_val_out, 32'hA5);
    check("load_en",   en_ctrl_out, 0);
    check("load_done_early", done_out, 0);
    @(negedge clk_in);
    check("load_set_off", set_ctrl_out, 0);
    check("load_done",    done_out, 1);
    check("load_val_hold", counter_val_out, 32'hA5);
    @(negedge clk_in);
    check("load_done_pulse", done_out, 0);
    check("load_idle_busy",  busy_out, 0);

    // UP 3 then DOWN 2 back-to-back, one gap cycle between them.
    push_cmd(OP_UP,   8'd0, 8'd3);
    push_cmd(OP_DOWN, 8'd0, 8'd2);
    capture(8, -1, en_t, up_t, done_t, to_t);
    check("updown_en",   en_t,   32'h37);
    check("updown_up",   up_t,   32'h0F);
    check("updown_done", done_t, 32'h48);

    // UP with len 0 runs 2^8 cycles.
    push_cmd(OP_UP, 8'd0, 8'd0);
    n_en = 0; got_done = 1'b0; got_to = 1'b0;
    for (int k = 0; k < 400 && !got_done; k++) begin
      @(negedge clk_in);
      if (en_ctrl_out) n_en++;
      if (done_out) begin
        got_done = 1'b1;
        got_to   = timeout_out;
      end
    end
    check("up_len0_en_cycles", 32'(n_en), 256);
    check("up_len0_done",      got_done, 1);
    check("up_len0_no_timeout", got_to, 0);

    // WAIT_OVF up, len 10, overflow on the 4th active cycle.
    push_cmd(OP_WAIT_OVF, 8'd1, 8'd10);
    capture(8, 4, en_t, up_t, done_t, to_t);
    check("wovf_en",      en_t,   32'h1E);
    check("wovf_up",      up_t,   32'hFF);
    check("wovf_done",    done_t, 32'h20);
    check("wovf_timeout", to_t,   32'h0);

    // Same command, no overflow: full timeout.
    push_cmd(OP_WAIT_OVF, 8'd1, 8'd10);
    capture(13, -1, en_t, up_t, done_t, to_t);
    check("wto_en",      en_t,   32'h7FE);
    check("wto_done",    done_t, 32'h800);
    check("wto_timeout", to_t,   32'h800);

    // Fill the FIFO behind a long RUN; six commands must run in order.
    base_done = done_seen;
    base_set  = set_log.size();
    push_cmd(OP_UP,   8'd0,  8'd50);
    push_cmd(OP_LOAD, 8'h11, 8'd0);
    push_cmd(OP_LOAD, 8'h22, 8'd0);
    push_cmd(OP_DOWN, 8'd0,  8'd2);
    push_cmd(OP_LOAD, 8'h33, 8'd0);
    @(negedge clk_in);
    check("fifo_full_ready", cmd_if.cmd_ready_out, 0);
    check("fifo_full_busy",  busy_out, 1);
    check("fifo_full_en",    en_ctrl_out, 1);
    push_cmd(OP_LOAD, 8'h44, 8'd0);
    for (int k = 0; k < 300 && (done_seen - base_done) < 6; k++) @(negedge clk_in);
    check("order_done_count", 32'(done_seen - base_done), 6);
    check("order_n_loads",    32'(set_log.size() - base_set), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("order_load%0d", i), set_log[base_set + i], exp_loads[i]);

    // Reset during the 5th active cycle of UP 20 with a LOAD still queued.
    push_cmd(OP_UP,   8'd0,  8'd20);
    push_cmd(OP_LOAD, 8'h5A, 8'd0);
    repeat (5) @(negedge clk_in);
    check("abort_running", en_ctrl_out, 1);
    base_done = done_seen;
    base_set  = set_log.size();
    rst_in = 1'b1;
    @(negedge clk_in);
    check("abort_en",    en_ctrl_out, 0);
    check("abort_up",    up_ctrl_out, 0);
    check("abort_val",   counter_val_out, 0);
    check("abort_busy",  busy_out, 0);
    check("abort_ready", cmd_if.cmd_ready_out, 1);
    rst_in = 1'b0;
    capture(30, -1, en_t, up_t, done_t, to_t);
    check("abort_no_en",    en_t, 0);
    check("abort_no_done",  32'(done_seen - base_done), 0);
    check("abort_no_load",  32'(set_log.size() - base_set), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
